// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receive front end (8N1, 8E1/8O1 with UART_RX_PARITY_EN defined).
// rcving rises once the start bit is confirmed at mid-bit and falls with done_rcving.
//
// state    | meaning
// IDLE     | line idle, waiting for sin_s low
// START    | start edge seen, waiting for mid-bit recheck
// DATA     | sampling data bits at mid-bit, LSB first
// PARITY   | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP     | sampling the stop bit
// BRK_WAIT | stop bit was low, waiting for the line to return high
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 sin,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rcving,
    output logic                 done_rcving,
    output logic                 framing_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [SAMP_W-1:0] SAMP_MID = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_END = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY   = 3'd5,
`endif
        BRK_WAIT = 3'd4
    } state_t;

    state_t               state;
    logic                 sin_meta;
    logic                 sin_s;
    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     div_lim;
    logic [SAMP_W-1:0]    samp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_meta <= 1'b1;
            sin_s    <= 1'b1;
        end else begin
            sin_meta <= sin;
            sin_s    <= sin_meta;
        end
    end

    // div_lim captures baud_div only at a wrap or a start edge, so a divisor change never splits a tick period
    assign tick = (div_cnt == div_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            div_lim     <= '0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rcving      <= 1'b0;
            done_rcving <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            done_rcving <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (tick) begin
                div_cnt <= '0;
                div_lim <= baud_div;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!sin_s) begin
                        state    <= START;
                        samp_cnt <= '0;
                        div_cnt  <= '0;
                        div_lim  <= baud_div;
                    end
                end
                START: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_MID) begin
                            samp_cnt <= '0;
                            if (sin_s) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                rcving  <= 1'b1;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_END) begin
                            samp_cnt <= '0;
                            shift    <= {sin_s, shift[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_END) begin
                            samp_cnt <= '0;
                            par_bit  <= sin_s;
                            state    <= STOP;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_END) begin
                            samp_cnt    <= '0;
                            rx_data     <= shift;
                            done_rcving <= 1'b1;
                            rcving      <= 1'b0;
                            framing_err <= !sin_s;
`ifdef UART_RX_PARITY_EN
                            parity_err  <= ((^shift) ^ par_bit) != parity_odd;
`endif
                            state       <= sin_s ? IDLE : BRK_WAIT;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                BRK_WAIT: begin
                    if (sin_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rcving <= 1'b0;
                end
            endcase
        end
    end

endmodule
